// File: rtl/modinv_helper_update_engine.sv
`default_nettype none
// ============================================================================
// Module   : modinv_helper_update_engine
// Brief    : One word-serial update step of a binary extended-GCD inverter.
//            Streams helper buffers into the r/s/u/v working buffers.
// Revision : 1.0
// ============================================================================
module modinv_helper_update_engine #(
    parameter int WORD_W     = 32,
    parameter int NUM_WORDS  = 9,
    parameter int ADDR_BITS  = 4,
    parameter int RD_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    output logic                 rdy,
    output logic                 done,
    output logic [2:0]           op,
    input  logic                 u_gt_v,
    input  logic                 v_eq_1,
    input  logic                 u_is_even,
    input  logic                 v_is_even,
    output logic [ADDR_BITS-1:0] src_addr,
    output logic [ADDR_BITS-1:0] dst_addr,
    output logic                 r_wren,
    output logic                 s_wren,
    output logic                 u_wren,
    output logic                 v_wren,
    output logic [WORD_W-1:0]    r_dout,
    output logic [WORD_W-1:0]    s_dout,
    output logic [WORD_W-1:0]    u_dout,
    output logic [WORD_W-1:0]    v_dout,
    input  logic [WORD_W-1:0]    r_dbl_din,
    input  logic [WORD_W-1:0]    s_dbl_din,
    input  logic [WORD_W-1:0]    r_plus_s_din,
    input  logic [WORD_W-1:0]    u_half_din,
    input  logic [WORD_W-1:0]    v_half_din,
    input  logic [WORD_W-1:0]    u_minus_v_half_din,
    input  logic [WORD_W-1:0]    v_minus_u_half_din
);

    // Counter must reach NUM_WORDS+RD_LATENCY-1 and also cover every address.
    localparam int CNT_RAW = $clog2(NUM_WORDS + RD_LATENCY);
    localparam int CNT_W   = (CNT_RAW > ADDR_BITS) ? CNT_RAW : ADDR_BITS;

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NUM_WORDS + RD_LATENCY - 1);
    localparam logic [CNT_W-1:0] C_LAT  = CNT_W'(RD_LATENCY);
    localparam logic [CNT_W-1:0] C_NW   = CNT_W'(NUM_WORDS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    localparam logic [2:0] OP_SKIP   = 3'd0;
    localparam logic [2:0] OP_U_EVEN = 3'd1;
    localparam logic [2:0] OP_V_EVEN = 3'd2;
    localparam logic [2:0] OP_U_GT_V = 3'd3;
    localparam logic [2:0] OP_V_GE_U = 3'd4;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_op;
    logic [2:0]       w_dec_op;
    logic             w_rd;
    logic             w_wr;

    always_comb begin
        if (v_eq_1)
            w_dec_op = OP_SKIP;
        else if (u_is_even)
            w_dec_op = OP_U_EVEN;
        else if (v_is_even)
            w_dec_op = OP_V_EVEN;
        else if (u_gt_v)
            w_dec_op = OP_U_GT_V;
        else
            w_dec_op = OP_V_GE_U;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= OP_SKIP;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (ena) begin
                        r_op    <= w_dec_op;
                        r_state <= v_eq_1 ? S_FIN : S_RUN;
                    end
                end
                S_RUN: begin
                    if (r_cnt == C_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_FIN;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_FIN:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rdy  = (r_state == S_IDLE);
    assign done = (r_state == S_FIN);
    assign op   = r_op;

    // Writes trail reads by the source latency; the counter never exceeds C_LAST in RUN.
    assign w_rd = (r_state == S_RUN) && (r_cnt < C_NW);
    assign w_wr = (r_state == S_RUN) && (r_cnt >= C_LAT);

    assign src_addr = w_rd ? ADDR_BITS'(r_cnt) : '0;
    assign dst_addr = w_wr ? ADDR_BITS'(r_cnt - C_LAT) : '0;

    always_comb begin
        r_wren = 1'b0;
        s_wren = 1'b0;
        u_wren = 1'b0;
        v_wren = 1'b0;
        r_dout = '0;
        s_dout = '0;
        u_dout = '0;
        v_dout = '0;
        if (w_wr) begin
            case (r_op)
                OP_U_EVEN: begin
                    u_wren = 1'b1;  u_dout = u_half_din;
                    s_wren = 1'b1;  s_dout = s_dbl_din;
                end
                OP_V_EVEN: begin
                    v_wren = 1'b1;  v_dout = v_half_din;
                    r_wren = 1'b1;  r_dout = r_dbl_din;
                end
                OP_U_GT_V: begin
                    u_wren = 1'b1;  u_dout = u_minus_v_half_din;
                    r_wren = 1'b1;  r_dout = r_plus_s_din;
                    s_wren = 1'b1;  s_dout = s_dbl_din;
                end
                OP_V_GE_U: begin
                    v_wren = 1'b1;  v_dout = v_minus_u_half_din;
                    r_wren = 1'b1;  r_dout = r_dbl_din;
                    s_wren = 1'b1;  s_dout = r_plus_s_din;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
